// File: rtl/dmem_sized_ram.sv
// Single-port 32-bit data memory with byte/half/word access, sign/zero-extended loads and a post-reset clear sweep.
// Optional per-lane even parity and the Perr output are enabled with `define DMEM_PARITY_EN.
module dmem_sized_ram #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] CLEAR_VAL = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              Rst_n,
  input  logic              En,
  input  logic              We,
  input  logic [1:0]        Size,
  input  logic              Sign,
  input  logic [ADDR_W+1:0] Addr,
  input  logic [31:0]       Wdata,
  output logic [31:0]       Rdata,
  output logic              Rvalid,
  output logic              Misalign,
  output logic              Busy,
`ifdef DMEM_PARITY_EN
  output logic              Perr,
`endif
  output logic              fsm_state
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Handshake: a request is sampled on any rising edge where En=1 and Busy=0.
  // Rvalid/Misalign pulse for exactly the following cycle; Rdata holds until the next load completes.
  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) clr_ptr <= clr_ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && (&clr_ptr)) state_nxt = S_RUN;
  end

  assign Busy      = (state == S_CLEAR);
  assign fsm_state = state;

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic              illegal;
  logic              run_req;
  logic              st_ok;
  logic              ld_ok;
  logic              sweep_we;
  logic [3:0]        be;
  logic [31:0]       wrep;

  assign word_idx = Addr[ADDR_W+1:2];
  assign lane     = Addr[1:0];

  always_comb begin
    illegal = 1'b0;
    case (Size)
      2'b01:   illegal = Addr[0];
      2'b10:   illegal = |Addr[1:0];
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  assign run_req = (state == S_RUN) && En;
  assign st_ok   = run_req && We && !illegal;
  assign ld_ok   = run_req && !We && !illegal;
  // The sweep must not touch memory while reset is held, only after release.
  assign sweep_we = Busy && Rst_n;

  // Right-aligned store data is replicated so every lane sees its bytes; be picks the lanes.
  always_comb begin
    be   = 4'b1111;
    wrep = Wdata;
    case (Size)
      2'b00: begin
        be   = 4'b0001 << lane;
        wrep = {4{Wdata[7:0]}};
      end
      2'b01: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{Wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = Wdata;
      end
    endcase
  end

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_word;

  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      mem[clr_ptr] <= CLEAR_VAL;
    end else if (st_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
    if (ld_ok) rd_word <= mem[word_idx];
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] rd_par;

  function automatic logic [3:0] lane_par(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      par_mem[clr_ptr] <= lane_par(CLEAR_VAL);
    end else if (st_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) par_mem[word_idx][i] <= ^wrep[8*i +: 8];
      end
    end
    if (ld_ok) rd_par <= par_mem[word_idx];
  end
`endif

  logic [1:0] ld_lane;
  logic [1:0] ld_size;
  logic       ld_sign;
  logic       ld_zero;

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      Rvalid   <= 1'b0;
      Misalign <= 1'b0;
      ld_lane  <= 2'b00;
      ld_size  <= 2'b10;
      ld_sign  <= 1'b0;
      ld_zero  <= 1'b1;
    end else begin
      Rvalid   <= run_req && !We;
      Misalign <= run_req && illegal;
      if (run_req && !We) begin
        ld_zero <= illegal;
        ld_lane <= lane;
        ld_size <= Size;
        ld_sign <= Sign;
      end
    end
  end

  // Extraction stays combinational on the captured word so Rdata holds without an extra register.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rd_word[{ld_lane, 3'b000} +: 8];
  assign ld_half = ld_lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    Rdata = '0;
    if (!ld_zero) begin
      case (ld_size)
        2'b00:   Rdata = {{24{ld_sign & ld_byte[7]}}, ld_byte};
        2'b01:   Rdata = {{16{ld_sign & ld_half[15]}}, ld_half};
        default: Rdata = rd_word;
      endcase
    end
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] ld_sel;

  always_comb begin
    ld_sel = 4'b1111;
    case (ld_size)
      2'b00:   ld_sel = 4'b0001 << ld_lane;
      2'b01:   ld_sel = ld_lane[1] ? 4'b1100 : 4'b0011;
      default: ld_sel = 4'b1111;
    endcase
  end

  assign Perr = Rvalid && !ld_zero && (|(ld_sel & (rd_par ^ lane_par(rd_word))));
`endif

endmodule

// File: tb/tb_dmem_sized_ram.sv
// Directed + randomised bench for dmem_sized_ram; a one-deep expected queue is checked the cycle after each request.
// Compile with +define+DMEM_PARITY_EN to add the parity-error scenario.
module tb_dmem_sized_ram;

  localparam int          ADDR_W    = 12;
  localparam int          DEPTH     = 4096;
  localparam logic [31:0] CLEAR_VAL = 32'h0000_0000;
  localparam int          W         = 35;

  logic              CLK;
  logic              Rst_n;
  logic              En;
  logic              We;
  logic [1:0]        Size;
  logic              Sign;
  logic [ADDR_W+1:0] Addr;
  logic [31:0]       Wdata;
  logic [31:0]       Rdata;
  logic              Rvalid;
  logic              Misalign;
  logic              Busy;
  logic              fsm_state;
  logic              perr_obs;
`ifdef DMEM_PARITY_EN
  logic              Perr;
`endif

  dmem_sized_ram #(.ADDR_W(ADDR_W), .CLEAR_VAL(CLEAR_VAL)) dut (
    .CLK      (CLK),
    .Rst_n    (Rst_n),
    .En       (En),
    .We       (We),
    .Size     (Size),
    .Sign     (Sign),
    .Addr     (Addr),
    .Wdata    (Wdata),
    .Rdata    (Rdata),
    .Rvalid   (Rvalid),
    .Misalign (Misalign),
    .Busy     (Busy),
`ifdef DMEM_PARITY_EN
    .Perr     (Perr),
`endif
    .fsm_state(fsm_state)
  );

`ifdef DMEM_PARITY_EN
  assign perr_obs = Perr;
`else
  assign perr_obs = 1'b0;
`endif

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [31:0]  model_mem [DEPTH];
  logic [31:0]  last_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign, input logic [13:0] addr);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = model_mem[addr[13:2]];
    b = w[int'(addr[1:0])*8 +: 8];
    h = w[int'(addr[1])*16 +: 16];
    case (size)
      2'b00:   return sign ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sign ? {{16{h[15]}}, h} : {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [13:0] addr, input logic [31:0] data);
    case (size)
      2'b00:   model_mem[addr[13:2]][int'(addr[1:0])*8 +: 8] = data[7:0];
      2'b01:   model_mem[addr[13:2]][int'(addr[1])*16 +: 16] = data[15:0];
      default: model_mem[addr[13:2]] = data;
    endcase
  endtask

  task automatic check_pending();
    logic [W-1:0] e;
    string        t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk($sformatf("%s.rvalid", t),   {31'h0, Rvalid},   {31'h0, e[33]});
      chk($sformatf("%s.misalign", t), {31'h0, Misalign}, {31'h0, e[32]});
      chk($sformatf("%s.rdata", t),    Rdata,             e[31:0]);
      chk($sformatf("%s.perr", t),     {31'h0, perr_obs}, {31'h0, e[34]});
    end
  endtask

  // driver: one request per negedge; the previous request's response is checked first
  task automatic req(input logic en, input logic we, input logic [1:0] size, input logic sign,
                     input logic [13:0] addr, input logic [31:0] wdata,
                     input bit use_want, input logic [31:0] want, input logic perr_want, input string tag);
    logic bad;
    logic rv;
    logic mis;
    @(negedge CLK);
    check_pending();
    En = en; We = we; Size = size; Sign = sign; Addr = addr; Wdata = wdata;
    bad = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    if (en && we && !bad) model_store(size, addr, wdata);
    rv  = en && !we;
    mis = en && bad;
    if (rv) last_rdata = bad ? 32'h0 : (use_want ? want : model_load(size, sign, addr));
    exp_q.push_back({perr_want && rv, rv, mis, last_rdata});
    tag_q.push_back(tag);
  endtask

  task automatic store(input logic [1:0] size, input logic [13:0] addr, input logic [31:0] d, input string tag);
    req(1'b1, 1'b1, size, 1'b0, addr, d, 1'b0, 32'h0, 1'b0, tag);
  endtask

  task automatic load(input logic [1:0] size, input logic sign, input logic [13:0] addr,
                      input logic [31:0] want, input string tag);
    req(1'b1, 1'b0, size, sign, addr, 32'h0, 1'b1, want, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    req(1'b0, 1'b0, 2'b10, 1'b0, 14'h0, 32'h0, 1'b0, 32'h0, 1'b0, tag);
  endtask

  // Counts rising edges from release until Busy falls; stray Rvalid/Misalign during the sweep is flagged.
  task automatic wait_sweep(input string tag);
    int   edges;
    logic stray;
    edges = 0;
    stray = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge CLK);
      edges++;
      #1;
      if (Rvalid || Misalign) stray = 1'b1;
      if (!Busy) break;
    end
    chk($sformatf("%s.busy_edges", tag), 32'(edges), 32'd4096);
    chk($sformatf("%s.no_resp_in_sweep", tag), {31'h0, stray}, 32'h0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = CLEAR_VAL;
    last_rdata = 32'h0;
  endtask

  initial begin
    Rst_n = 1'b0; En = 1'b0; We = 1'b0; Size = 2'b10; Sign = 1'b0; Addr = '0; Wdata = '0;
    last_rdata = 32'h0;
    repeat (3) @(negedge CLK);
    chk("rst.busy",      {31'h0, Busy},      32'h1);
    chk("rst.rvalid",    {31'h0, Rvalid},    32'h0);
    chk("rst.misalign",  {31'h0, Misalign},  32'h0);
    chk("rst.rdata",     Rdata,              32'h0);
    chk("rst.state",     {31'h0, fsm_state}, 32'h0);
    chk("rst.perr",      {31'h0, perr_obs},  32'h0);
    Rst_n = 1'b1;
    wait_sweep("sweep1");
    chk("run.state", {31'h0, fsm_state}, 32'h1);

    // first load after the sweep
    load(2'b10, 1'b0, 14'h0000, CLEAR_VAL, "t1_lw0");

    // back-to-back word loads
    store(2'b10, 14'h1028, 32'h0000_0077, "t2_sw28");
    store(2'b10, 14'h102C, 32'h0000_0078, "t2_sw2c");
    load(2'b10, 1'b0, 14'h1028, 32'h0000_0077, "t2_lw28");
    load(2'b10, 1'b0, 14'h102C, 32'h0000_0078, "t2_lw2c");
    idle("t2_hold");

    // byte store into a word, signed and unsigned byte loads
    store(2'b10, 14'h0000, 32'h1122_3344, "t3_sw0");
    store(2'b00, 14'h0002, 32'h0000_00AA, "t3_sb2");
    load(2'b10, 1'b0, 14'h0000, 32'h11AA_3344, "t3_lw0");
    load(2'b00, 1'b1, 14'h0002, 32'hFFFF_FFAA, "t3_lb2");
    load(2'b00, 1'b0, 14'h0002, 32'h0000_00AA, "t3_lbu2");

    // halfword extension and misaligned requests
    store(2'b10, 14'h0004, 32'h8001_7FFF, "t4_sw4");
    load(2'b01, 1'b1, 14'h0006, 32'hFFFF_8001, "t4_lh6");
    load(2'b01, 1'b0, 14'h0006, 32'h0000_8001, "t4_lhu6");
    load(2'b01, 1'b1, 14'h0004, 32'h0000_7FFF, "t4_lh4");
    store(2'b01, 14'h0005, 32'h0000_1234, "t4_sh5_mis");
    load(2'b10, 1'b0, 14'h0004, 32'h8001_7FFF, "t4_lw4");
    load(2'b10, 1'b0, 14'h0006, 32'h0, "t4_lw6_mis");
    load(2'b11, 1'b0, 14'h0000, 32'h0, "t4_size3_mis");
    idle("t4_hold");

`ifdef DMEM_PARITY_EN
    store(2'b10, 14'h0008, 32'hDEAD_BEEF, "t6_sw8");
    idle("t6_idle");
    dut.par_mem[2][1] = ~dut.par_mem[2][1];
    req(1'b1, 1'b0, 2'b00, 1'b0, 14'h0009, 32'h0, 1'b1, 32'h0000_00BE, 1'b1, "t6_lbu9_perr");
    req(1'b1, 1'b0, 2'b00, 1'b0, 14'h0008, 32'h0, 1'b1, 32'h0000_00EF, 1'b0, "t6_lbu8_ok");
    idle("t6_hold");
`endif

    // random mix over a small window so stores and loads collide
    for (int n = 0; n < 60; n++) begin
      logic [13:0] a;
      logic [1:0]  sz;
      a  = 14'(256 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3));
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       req(1'b1, 1'b1, sz, 1'b0, a, $urandom, 1'b0, 32'h0, 1'b0, $sformatf("rnd%0d_st", n));
        1:       req(1'b1, 1'b0, sz, 1'($urandom_range(0, 1)), a, 32'h0, 1'b0, 32'h0, 1'b0, $sformatf("rnd%0d_ld", n));
        default: idle($sformatf("rnd%0d_idle", n));
      endcase
    end
    idle("rnd_drain");
    @(negedge CLK);
    check_pending();

    // requests during the sweep are ignored; reset mid-sweep restarts it
    Rst_n = 1'b0;
    @(negedge CLK);
    Rst_n = 1'b1;
    En = 1'b1; We = 1'b1; Size = 2'b10; Addr = 14'h0000; Wdata = 32'hCAFE_F00D;
    repeat (100) begin
      @(posedge CLK);
      #1;
      chk("t5_busy_store_ignored", {30'h0, Rvalid, Misalign}, 32'h0);
    end
    @(negedge CLK);
    Rst_n = 1'b0;
    @(negedge CLK);
    chk("t5_midrst.busy",  {31'h0, Busy},      32'h1);
    chk("t5_midrst.state", {31'h0, fsm_state}, 32'h0);
    Rst_n = 1'b1;
    wait_sweep("sweep2");
    load(2'b10, 1'b0, 14'h0000, CLEAR_VAL, "t5_lw0");
    load(2'b10, 1'b0, 14'h1028, CLEAR_VAL, "t5_lw1028");
    idle("t5_hold");
    @(negedge CLK);
    check_pending();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
